fpu_issue_sched: RTL and testbench
==================================

// Module: fpu_issue_sched
// PURPOSE
//  Issue scheduler for the fixed-latency FPU units (fadd, fmul, fcvt, fdiv, fmisc) behind a single FP writeback port.
//  Accepts one op/cycle from decode and pulses the target unit's start strobe.
//  Reserves the writeback slot L cycles ahead, blocks WAW on rd, and serialises the non-pipelined divider.
//  Drives writeback valid/rd/unit-select to the FP register file mux.
// PARAMETERS
//  LAT_FADD   3   fadd/fsub latency, cycles start->result (pipelined)
//  LAT_FMUL   2   fmul latency (pipelined)
//  LAT_FCVT   5   fcvt.s.w / fcvt.w.s latency (pipelined)
//  LAT_FDIV   12  fdiv/fsqrt latency (NOT pipelined)
//  LAT_FMISC  1   fsgnj/fmv/compare latency (pipelined)
//  MAX_LAT    16  reservation depth; every LAT_* must satisfy 1 <= LAT_* <= MAX_LAT
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  issue_valid  in   1   decode offers an FP op
//  issue_unit   in   3   fpu_pkg::unit_e: FADD=0 FMUL=1 FCVT=2 FDIV=3 FMISC=4
//  issue_rd     in   5   destination FP register
//  issue_ready  out  1   op accepted this cycle when issue_valid&issue_ready
//  unit_start   out  5   one-hot start strobe, bit = unit_e, same cycle as accept
//  flush        in   1   kill all in-flight ops (branch mispredict/trap)
//  wb_valid     out  1   result written this cycle
//  wb_rd        out  5   writeback register
//  wb_unit      out  3   result mux select (unit_e)
//  pending      out  32  scoreboard: bit r set while rd=r in flight
// BEHAVIOUR
//  - Reservation array res[0..MAX_LAT-1] of {v,rd,unit}; shifts res[k]<=res[k+1] every cycle; res[MAX_LAT-1] fills with invalid.
//  - Accept at cycle t with latency L writes res[L-1] at edge t->t+1; entry reaches res[0] at t+L.
//    wb_valid=res[0].v&~flush, wb_rd/wb_unit=res[0] fields.
//  - issue_ready = ~rst & ~flush & slot_free & ~pending[issue_rd] & ~(unit==FDIV & div_cnt!=0).
//    slot_free = (L==MAX_LAT) | ~res[L].v.
//  - issue_ready is combinational and may depend on issue_unit/issue_rd; decode must not wait for ready before asserting valid.
//  - unit_start[u] = issue_valid&issue_ready&(issue_unit==u); all zero otherwise.
//  - Divider: div_cnt loads LAT_FDIV-1 on FDIV accept, decrements to 0; next FDIV accepts no earlier than t+LAT_FDIV.
//  - div_cnt ignores flush: the unit keeps running internally; only its result is dropped.
//  - Scoreboard: pending[rd] set on accept, cleared when that entry writes back.
//    Same-rd set and clear in one cycle cannot occur (WAW stall); a set on one rd and a clear on another both apply.
//  - WAW: an rd that is pending stalls issue, even in the cycle it writes back; issue proceeds the next cycle.
//  - Slot collision: a short op whose slot is taken stalls; no reordering or retry queue.
//  - flush: in that cycle wb_valid=0 and no accept; at the edge all res[*].v<=0 and pending<=0.
//  - Reset (sync): res all invalid, pending=0, div_cnt=0.
//    During rst: issue_ready=0, unit_start=0, wb_valid=0, wb_rd=0, wb_unit=0.
//  - rst asserted mid-operation discards all in-flight ops, with no writeback after release.
//  - Illegal issue_unit (5..7): issue_ready=0, never accepted.
// STRUCTURE
//  - fpu_pkg: unit_e enum, resv_t struct {v,rd,unit}, default LAT_* localparams, lat_of(unit_e) function.
//  - Sub-module fpu_resv_shift (MAX_LAT-deep shifting reservation array, write port at index L-1, flush/reset clear).
//    Scoreboard and div counter stay in the top level.
// TESTING
//  - Reset: hold rst 2 cycles with issue_valid=1 -> issue_ready=0, unit_start=0, wb_valid=0, pending=0.
//  - Single FCVT rd=7 accepted at t -> unit_start=00100 at t.
//    pending[7]=1 during t+1..t+5, then wb_valid=1, wb_rd=7, wb_unit=2 at t+5 only; pending[7]=0 at t+6.
//  - Collision: FCVT rd=1 at t, FADD rd=2 at t+2 (both target t+5) -> FADD stalls at t+2.
//    FADD accepts at t+3 with wb at t+6; wb order 1 then 2, no lost result.
//  - WAW/back-to-back: FMUL rd=3 at t, FMUL rd=3 offered t+1 -> stall until t+3, wb rd=3 at t+2 and t+5.
//    FMUL rd=4 at t+1 accepts, wb at t+3.
//  - Divider: FDIV rd=5 at t, FDIV rd=6 offered from t+1 -> accepted at t+12.
//    Interleaved FMISC rd=8 at t+4 accepts with wb at t+5.
//  - Flush: FCVT rd=9 at t, flush at t+2 -> no wb at t+5, pending=0 from t+3.
//    FDIV after flush with div_cnt!=0 still stalls until the counter reaches 0.
//  - Random soak: random unit/rd/flush each cycle, scoreboard model -> exactly one wb per accepted unflushed op at t+L.
//    Never two writebacks in one cycle.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue scheduler: unit encoding, reservation entry,
// default unit latencies.
package fpu_pkg;

   typedef enum logic [2:0] {
      U_FADD  = 3'd0,
      U_FMUL  = 3'd1,
      U_FCVT  = 3'd2,
      U_FDIV  = 3'd3,
      U_FMISC = 3'd4
   } unit_e;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      unit_e      unit;
   } resv_t;

   localparam int DEF_LAT_FADD  = 3;
   localparam int DEF_LAT_FMUL  = 2;
   localparam int DEF_LAT_FCVT  = 5;
   localparam int DEF_LAT_FDIV  = 12;
   localparam int DEF_LAT_FMISC = 1;
   localparam int DEF_MAX_LAT   = 16;

   function automatic int lat_of(unit_e u);
      case (u)
         U_FADD:  return DEF_LAT_FADD;
         U_FMUL:  return DEF_LAT_FMUL;
         U_FCVT:  return DEF_LAT_FCVT;
         U_FDIV:  return DEF_LAT_FDIV;
         U_FMISC: return DEF_LAT_FMISC;
         default: return 1;
      endcase
   endfunction

endpackage

// File: rtl/fpu_resv_shift.sv
// Writeback reservation array: entry k writes back k cycles from now.
// Shifts toward index 0 every cycle; one write port for a newly accepted op.
module fpu_resv_shift
   import fpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int IW    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [IW-1:0]         wr_idx,
   input  resv_t                 wr_data,
   output resv_t [DEPTH-1:0]     res
);

   resv_t [DEPTH-1:0] shifted;

   assign shifted = res >> $bits(resv_t);

   // The write slot was checked free one index higher, so it never collides
   // with a shifting entry.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         res <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (wr_en && (wr_idx == IW'(k))) res[k] <= wr_data;
            else                             res[k] <= shifted[k];
         end
      end
   end

endmodule

// File: rtl/fpu_issue_sched.sv
// FP issue scheduler: one op/cycle into fixed-latency units sharing a single
// writeback port; slot reservation, WAW stall, divider serialisation.
module fpu_issue_sched
   import fpu_pkg::*;
#(
   parameter int LAT_FADD  = DEF_LAT_FADD,
   parameter int LAT_FMUL  = DEF_LAT_FMUL,
   parameter int LAT_FCVT  = DEF_LAT_FCVT,
   parameter int LAT_FDIV  = DEF_LAT_FDIV,
   parameter int LAT_FMISC = DEF_LAT_FMISC,
   parameter int MAX_LAT   = DEF_MAX_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [2:0]  issue_unit,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   output logic [4:0]  unit_start,
   input  logic        flush,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [2:0]  wb_unit,
   output logic [31:0] pending
);

   localparam int IW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int CW = IW + 1;

   resv_t [MAX_LAT-1:0] res;
   resv_t               wr_data;
   logic [CW-1:0]       lat;
   logic [CW-1:0]       div_cnt;
   logic [IW-1:0]       wr_idx;
   logic                legal;
   logic                slot_free;
   logic                div_busy;
   logic                accept;
   logic [31:0]         set_mask;
   logic [31:0]         clr_mask;

   always_comb begin
      lat   = CW'(LAT_FMISC);
      legal = 1'b1;
      case (issue_unit)
         3'd0:    lat = CW'(LAT_FADD);
         3'd1:    lat = CW'(LAT_FMUL);
         3'd2:    lat = CW'(LAT_FCVT);
         3'd3:    lat = CW'(LAT_FDIV);
         3'd4:    lat = CW'(LAT_FMISC);
         default: legal = 1'b0;
      endcase
   end

   // res[lat] shifts into the target slot at the same edge as our write.
   always_comb begin
      slot_free = 1'b1;
      if (lat != CW'(MAX_LAT)) slot_free = ~res[lat[IW-1:0]].v;
   end

   assign div_busy    = (issue_unit == 3'd3) && (div_cnt != '0);
   assign issue_ready = ~rst & ~flush & legal & slot_free & ~pending[issue_rd] & ~div_busy;
   assign accept      = issue_valid & issue_ready;
   assign unit_start  = accept ? (5'b1 << issue_unit) : 5'b0;

   assign wr_idx  = IW'(lat - CW'(1));
   assign wr_data = '{v: 1'b1, rd: issue_rd, unit: unit_e'(issue_unit)};

   fpu_resv_shift #(.DEPTH(MAX_LAT), .IW(IW)) u_resv (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .wr_en   (accept),
      .wr_idx  (wr_idx),
      .wr_data (wr_data),
      .res     (res)
   );

   assign wb_valid = ~rst & ~flush & res[0].v;
   assign wb_rd    = rst ? 5'd0 : res[0].rd;
   assign wb_unit  = rst ? 3'd0 : res[0].unit;

   assign set_mask = accept   ? (32'd1 << issue_rd)  : 32'd0;
   assign clr_mask = wb_valid ? (32'd1 << res[0].rd) : 32'd0;

   always_ff @(posedge clk) begin
      if (rst || flush) pending <= '0;
      else              pending <= (pending & ~clr_mask) | set_mask;
   end

   // Divider keeps running through a flush; only its result is dropped.
   always_ff @(posedge clk) begin
      if (rst)                          div_cnt <= '0;
      else if (accept && div_busy == 1'b0 && issue_unit == 3'd3)
                                        div_cnt <= CW'(LAT_FDIV - 1);
      else if (div_cnt != '0)           div_cnt <= div_cnt - CW'(1);
   end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: directed scenarios plus random soak against a
// cycle-level scoreboard of in-flight ops.
module tb_fpu_issue_sched;
   import fpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, issue_valid, flush;
   logic [2:0]  issue_unit;
   logic [4:0]  issue_rd;
   logic        issue_ready, wb_valid;
   logic [4:0]  unit_start, wb_rd;
   logic [2:0]  wb_unit;
   logic [31:0] pending;

   fpu_issue_sched dut (
      .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
      .issue_rd(issue_rd), .issue_ready(issue_ready), .unit_start(unit_start),
      .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_unit(wb_unit),
      .pending(pending)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   typedef struct {
      int         due;
      logic [4:0] rd;
      logic [2:0] unit;
   } ent_t;

   ent_t sb[$];
   ent_t keep[$];
   int   div_next = 0;
   bit   armed = 0;

   function automatic bit model_ready();
      int l;
      if (rst || flush || issue_unit > 3'd4) return 1'b0;
      l = lat_of(unit_e'(issue_unit));
      foreach (sb[i]) if (sb[i].due == cyc + l || sb[i].rd == issue_rd) return 1'b0;
      if (issue_unit == 3'd3 && cyc < div_next) return 1'b0;
      return 1'b1;
   endfunction

   // Scoreboard: predicts every output from the queue of in-flight ops.
   always @(negedge clk) begin
      bit          er;
      logic [31:0] ep;
      logic [31:0] es;
      int          hit;
      int          l;
      er  = model_ready();
      ep  = '0;
      hit = -1;
      foreach (sb[i]) begin
         ep[sb[i].rd] = 1'b1;
         if (sb[i].due == cyc) hit = i;
      end
      es = (issue_valid && er) ? 32'(5'b1 << issue_unit) : 32'd0;
      if (armed) begin
         chk("ready", issue_ready, er);
         chk("start", unit_start, es);
         chk("pending", pending, ep);
         if (hit >= 0 && !rst && !flush) begin
            chk("wb_valid", wb_valid, 1);
            chk("wb_rd", wb_rd, sb[hit].rd);
            chk("wb_unit", wb_unit, sb[hit].unit);
         end else begin
            chk("wb_idle", wb_valid, 0);
            if (rst) begin
               chk("wb_rd_rst", wb_rd, 0);
               chk("wb_unit_rst", wb_unit, 0);
            end
         end
      end
      keep.delete();
      foreach (sb[i]) if (sb[i].due != cyc) keep.push_back(sb[i]);
      sb = keep;
      if (rst || flush) sb.delete();
      if (rst) div_next = 0;
      if (issue_valid && er) begin
         l = lat_of(unit_e'(issue_unit));
         sb.push_back('{cyc + l, issue_rd, issue_unit});
         if (issue_unit == 3'd3) div_next = cyc + DEF_LAT_FDIV;
      end
      if (rst) armed = 1;
   end

   task automatic drive(bit v, logic [2:0] u, logic [4:0] r, bit f = 0, bit rs = 0);
      @(posedge clk);
      #1;
      issue_valid = v; issue_unit = u; issue_rd = r; flush = f; rst = rs;
   endtask

   task automatic idle(int n);
      repeat (n) drive(0, 3'd0, 5'd0);
   endtask

   initial begin
      bit got;
      int acc;
      rst = 1; issue_valid = 1; issue_unit = U_FADD; issue_rd = 0; flush = 0;
      @(posedge clk); @(posedge clk); #3;
      chk("rst_ready", issue_ready, 0);
      chk("rst_start", unit_start, 0);
      chk("rst_wb", wb_valid, 0);
      chk("rst_pending", pending, 0);
      idle(2);

      // single FCVT
      drive(1, U_FCVT, 7); #2;
      chk("fcvt_ready", issue_ready, 1);
      chk("fcvt_start", unit_start, 5'b00100);
      for (int i = 1; i <= 6; i++) begin
         drive(0, 3'd0, 5'd0); #2;
         chk("fcvt_p7", pending[7], i <= 5);
         chk("fcvt_wb", wb_valid, i == 5);
         if (i == 5) begin
            chk("fcvt_wb_rd", wb_rd, 7);
            chk("fcvt_wb_unit", wb_unit, 2);
         end
      end
      idle(2);

      // slot collision
      drive(1, U_FCVT, 1);
      idle(1);
      drive(1, U_FADD, 2); #2; chk("coll_stall", issue_ready, 0);
      drive(1, U_FADD, 2); #2; chk("coll_go", issue_ready, 1);
      idle(7);

      // WAW on rd=3, then independent rd=4
      drive(1, U_FMUL, 3);
      drive(1, U_FMUL, 3); #2; chk("waw_stall1", issue_ready, 0);
      drive(1, U_FMUL, 3); #2; chk("waw_stall2", issue_ready, 0);
      chk("waw_wb1", wb_valid, 1); chk("waw_wb1_rd", wb_rd, 3);
      drive(1, U_FMUL, 3); #2; chk("waw_go", issue_ready, 1);
      idle(4);
      drive(1, U_FMUL, 3);
      drive(1, U_FMUL, 4); #2; chk("b2b_go", issue_ready, 1);
      idle(4);

      // divider serialisation with interleaved FMISC
      drive(1, U_FDIV, 5);
      for (int i = 1; i <= 12; i++) begin
         if (i == 4) begin
            drive(1, U_FMISC, 8); #2; chk("div_fmisc", issue_ready, 1);
         end else begin
            drive(1, U_FDIV, 6); #2; chk("div_wait", issue_ready, i == 12);
         end
      end
      idle(14);

      // flush kills FCVT in flight
      drive(1, U_FCVT, 9);
      idle(1);
      drive(0, 3'd0, 5'd0, 1); #2; chk("flush_ready", issue_ready, 0);
      drive(0, 3'd0, 5'd0); #2; chk("flush_pending", pending, 0);
      idle(5);

      // flush does not reset the divider counter
      drive(1, U_FDIV, 10);
      drive(1, U_FDIV, 11, 1); #2; chk("divflush_ready", issue_ready, 0);
      got = 0; acc = -1;
      for (int i = 2; i < 20 && !got; i++) begin
         drive(1, U_FDIV, 11); #2;
         if (issue_ready) begin got = 1; acc = i; end
      end
      chk("divflush_acc", acc, 12);
      idle(14);

      // reset mid-operation
      drive(1, U_FCVT, 12);
      drive(0, 3'd0, 5'd0, 0, 1);
      idle(8);
      chk("midrst_pending", pending, 0);

      // illegal units
      for (int u = 5; u <= 7; u++) begin
         drive(1, 3'(u), 13); #2; chk("illegal", issue_ready, 0);
      end
      idle(1);

      // random soak
      repeat (2000) begin
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 5)),
               5'($urandom_range(0, 7)), $urandom_range(0, 39) == 0);
      end
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
